// File: rtl/b_mux_arbiter.sv
// b_mux_arbiter: two-requester round-robin arbiter driving a shared 2:1 mux.
// A three-state FSM (IDLE / GNT0 / GNT1) owns the grant. The mux output and
// its valid flag are registered one edge behind the grant.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a granted
// requester that has held the grant for MAX_HOLD cycles gives it up to a
// waiting peer. When it is undefined, a grant lasts as long as its request.

module b_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    // Each state's encoding matches the grant vector it drives.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GNT0 = 2'b01,
        S_GNT1 = 2'b10
    } state_t;

    // Reject an out-of-range hold limit at elaboration.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("b_mux_arbiter: MAX_HOLD must be in 2..255");
    end

    state_t           r_state;
    state_t           w_next;
    logic             r_last;       // requester that received the most recent grant
    logic [7:0]       r_hold_cnt;   // edges spent in the current grant
    logic             w_timeout;    // current holder has reached its cycle limit
    logic             w_serve;      // current holder is still requesting
    logic [WIDTH-1:0] w_mux;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    assign w_timeout = (r_hold_cnt == HOLD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A contended IDLE grant goes to the requester not served last.
    // NOTE: w_next gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                case (req)
                    2'b01:   w_next = S_GNT0;
                    2'b10:   w_next = S_GNT1;
                    2'b11:   w_next = r_last ? S_GNT0 : S_GNT1;
                    default: w_next = S_IDLE;
                endcase
            end
            S_GNT0: begin
                if (req[0] && !(w_timeout && req[1])) w_next = S_GNT0;
                else if (req[1])                      w_next = S_GNT1;
                else                                  w_next = S_IDLE;
            end
            S_GNT1: begin
                if (req[1] && !(w_timeout && req[0])) w_next = S_GNT1;
                else if (req[0])                      w_next = S_GNT0;
                else                                  w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: the grant and the mux select come straight from the state register.
    always_comb begin
        gnt = 2'b00;
        case (r_state)
            S_GNT0:  gnt = 2'b01;
            S_GNT1:  gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
        sel = gnt[1];
    end

    // Remember the last requester served. It resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_next == S_GNT0 && r_state != S_GNT0) begin
            r_last <= 1'b0;
        end else if (w_next == S_GNT1 && r_state != S_GNT1) begin
            r_last <= 1'b1;
        end
    end

    // Hold counter: clears when the grant changes and counts edges held, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state != S_IDLE && r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_serve = (r_state == S_GNT0 && req[0]) || (r_state == S_GNT1 && req[1]);
    assign w_mux   = sel ? d1 : d0;

    // Datapath: capture the granted requester's data while it keeps requesting, otherwise hold y.
    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else if (w_serve) begin
            y       <= w_mux;
            y_valid <= 1'b1;
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_b_mux_arbiter.sv
// Self-checking bench for b_mux_arbiter: directed scenarios from the block's
// examples, then randomized traffic compared against a behavioural model.

module tb_b_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [1:0]       gnt;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner is 0 (idle) or 1+k (requester k holds the grant).
    int         m_owner = 0;
    int         m_last  = 1;
    int         m_held  = 0;
    logic [7:0] m_y     = '0;
    logic       m_yv    = 1'b0;

    b_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the arbitration rules directly.
    function automatic void model_edge(input logic r, input logic [1:0] q,
                                       input logic [7:0] a, input logic [7:0] b);
        int nxt;
        int k;
        bit limit;
        if (r) begin
            m_owner = 0; m_last = 1; m_held = 0; m_y = '0; m_yv = 1'b0;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (q == 2'b01)      nxt = 1;
            else if (q == 2'b10) nxt = 2;
            else if (q == 2'b11) nxt = (m_last == 1) ? 1 : 2;
            m_yv = 1'b0;
        end else begin
            k = m_owner - 1;
            if (q[k]) begin
                m_y  = (k == 1) ? b : a;
                m_yv = 1'b1;
            end else begin
                m_yv = 1'b0;
            end
            limit = 1'b0;
`ifdef ARB_TIMEOUT_EN
            limit = (m_held == MAX_HOLD - 1);
`endif
            if (q[k] && !(limit && q[1-k])) nxt = m_owner;
            else if (q[1-k])                nxt = (1 - k) + 1;
            else                            nxt = 0;
        end
        if (nxt != m_owner) begin
            m_held = 0;
            if (nxt != 0) m_last = nxt - 1;
        end else if (m_owner != 0 && m_held < 255) begin
            m_held++;
        end
        m_owner = nxt;
    endfunction

    // Drive inputs, advance one edge, then compare all outputs with the model mid-cycle.
    task automatic step(input logic r, input logic [1:0] q, input logic [7:0] a, input logic [7:0] b);
        logic [1:0] exp_gnt;
        rst = r; req = q; d0 = a; d1 = b;
        model_edge(r, q, a, b);
        @(posedge clk);
        @(negedge clk);
        exp_gnt = (m_owner == 0) ? 2'b00 : (m_owner == 1) ? 2'b01 : 2'b10;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("sel", 32'(sel), 32'(exp_gnt[1]));
        check("y", 32'(y), 32'(m_y));
        check("y_valid", 32'(y_valid), 32'(m_yv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] y_hold;
        rst = 1'b1; req = 2'b00; d0 = '0; d1 = '0;

        // Reset state.
        step(1'b1, 2'b00, 8'h11, 8'h22);
        step(1'b1, 2'b00, 8'h11, 8'h22);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_y", 32'(y), 32'h0);
        check("rst_yv", 32'(y_valid), 32'h0);

        // Single requester: grant after edge 1, data after edge 2.
        step(1'b0, 2'b01, 8'hA5, 8'h00);
        check("lat_gnt", 32'(gnt), 32'h1);
        check("lat_yv0", 32'(y_valid), 32'h0);
        step(1'b0, 2'b01, 8'hA5, 8'h00);
        check("lat_y", 32'(y), 32'hA5);
        check("lat_yv1", 32'(y_valid), 32'h1);
        step(1'b0, 2'b00, 8'h00, 8'h00);

        // First contention after reset goes to requester 0, then direct hand-off.
        step(1'b1, 2'b00, 8'h00, 8'h00);
        step(1'b0, 2'b11, 8'h01, 8'h02);
        check("cont_first", 32'(gnt), 32'h1);
        step(1'b0, 2'b10, 8'h01, 8'h02);
        check("handoff", 32'(gnt), 32'h2);

        // Release to idle, then contention: requester 0 is next (last served was 1).
        step(1'b0, 2'b00, 8'h01, 8'h02);
        check("release", 32'(gnt), 32'h0);
        step(1'b0, 2'b11, 8'h03, 8'h04);
        check("round_robin", 32'(gnt), 32'h1);

        // Reset pulse in the middle of a GNT1 transfer.
        step(1'b0, 2'b10, 8'h05, 8'h06);
        check("mid_gnt1", 32'(gnt), 32'h2);
        step(1'b0, 2'b10, 8'h05, 8'h66);
        check("mid_y", 32'(y), 32'h66);
        step(1'b1, 2'b10, 8'h05, 8'h77);
        check("abort_gnt", 32'(gnt), 32'h0);
        check("abort_y", 32'(y), 32'h0);
        check("abort_yv", 32'(y_valid), 32'h0);
        step(1'b0, 2'b10, 8'h05, 8'h77);
        check("regrant", 32'(gnt), 32'h2);

        // Idle for three cycles: y holds its last captured value.
        step(1'b0, 2'b10, 8'h05, 8'h3C);
        y_hold = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 8'hFF, 8'hEE);
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_yv", 32'(y_valid), 32'h0);
            check("idle_y", 32'(y), 32'(y_hold));
        end

        // Both requesting continuously: alternates every MAX_HOLD cycles only with the timeout.
        step(1'b1, 2'b00, 8'h00, 8'h00);
        for (int i = 0; i < 12; i++) begin
            logic [1:0] want;
`ifdef ARB_TIMEOUT_EN
            want = (((i / MAX_HOLD) % 2) == 0) ? 2'b01 : 2'b10;
`else
            want = 2'b01;
`endif
            step(1'b0, 2'b11, 8'(i), 8'(i + 100));
            check("hold11", 32'(gnt), 32'(want));
        end

        // Long single-requester hold, past counter saturation.
        for (int i = 0; i < 270; i++) begin
            step(1'b0, 2'b10, 8'(i), 8'(255 - i));
        end
        check("long_hold", 32'(gnt), 32'h2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [1:0] q;
            r = ($urandom_range(0, 39) == 0);
            q = 2'($urandom);
            if ($urandom_range(0, 3) == 0) q = 2'b11;
            step(r, q, 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
